lsu_misalign_unit: RTL and testbench

Core-side load/store initiator that sits between the execute stage and the data memory port. It takes one load/store request at a time from the pipeline and handles RV32I byte, half and word accesses at any byte offset. A misaligned access is split into two word-aligned memory accesses. It drives word-aligned addresses with per-byte write enables and lane-positioned write data, then sign- or zero-extends returning load data.

---
 rtl/lsu_pkg.sv | 51 +++++
 rtl/lsu_misalign_unit_if.sv | 36 +++
 rtl/lsu_lane_align.sv | 40 ++++
 rtl/lsu_misalign_unit.sv | 158 +++++++++++++++
 tb/tb_lsu_misalign_unit.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Purpose  : Shared types and helpers for the load/store misalignment unit.
// Revision : 1.0
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    // Any code that is not a byte or half access is handled as a word.
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            F3_W:        return SZ_W;
            default:     return SZ_W;
        endcase
    endfunction

    function automatic logic f3_unsigned(input logic [2:0] f3);
        return (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

    function automatic logic [3:0] base_mask(input size_t sz);
        case (sz)
            SZ_B:    return 4'b0001;
            SZ_H:    return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_misalign_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_misalign_unit_if
// Purpose  : Pipeline request/response and data-memory port bundle.
// Revision : 1.0
// ============================================================================
interface lsu_misalign_unit_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [2:0]            req_funct3;
    logic [DM_ADDRESS-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic                  resp_valid;
    logic [DATA_W-1:0]     resp_rdata;
    logic                  mem_re;
    logic [3:0]            mem_wr;
    logic [DM_ADDRESS-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W-1:0]     mem_rdata;

    // Master is the surrounding environment: the pipeline plus data memory.
    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, mem_re, mem_wr, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata, mem_re, mem_wr, mem_addr, mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_lane_align
// Purpose  : Store rotate, 8-bit byte mask and load shift/extend (combinational).
// Revision : 1.0
// ============================================================================
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  size_t             i_size,
    input  logic              i_uns,
    input  logic [1:0]        i_off,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_word0,
    input  logic [DATA_W-1:0] i_word1,
    output logic [DATA_W-1:0] o_wdata_rot,
    output logic [7:0]        o_mask,
    output logic              o_split,
    output logic [DATA_W-1:0] o_rdata_ext
);
    logic [5:0]        w_shamt;
    logic [DATA_W-1:0] w_rlow;

    always_comb begin
        w_shamt     = {1'b0, i_off, 3'b000};
        // A shift by the full width yields zero, so offset 0 passes data through.
        o_wdata_rot = (i_wdata << w_shamt) | (i_wdata >> (6'd32 - w_shamt));
        o_mask      = {4'b0000, base_mask(i_size)} << i_off;
        o_split     = |o_mask[7:4];
        w_rlow      = DATA_W'({i_word1, i_word0} >> w_shamt);
        case (i_size)
            SZ_B:    o_rdata_ext = {{(DATA_W-8){~i_uns & w_rlow[7]}}, w_rlow[7:0]};
            SZ_H:    o_rdata_ext = {{(DATA_W-16){~i_uns & w_rlow[15]}}, w_rlow[15:0]};
            default: o_rdata_ext = w_rlow;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/lsu_misalign_unit.sv
`default_nettype none
// ============================================================================
// Module   : lsu_misalign_unit
// Purpose  : Load/store initiator splitting misaligned accesses into two words.
// Revision : 1.0
// ============================================================================
module lsu_misalign_unit
    import lsu_pkg::*;
#(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic               clk,
    input  logic               reset,
    lsu_misalign_unit_if.slave bus
);
    localparam int c_WIDX_W = DM_ADDRESS - 2;

    state_t                r_state, w_state_nxt;
    logic                  r_we, r_uns, r_split;
    size_t                 r_size;
    logic [1:0]            r_off;
    logic [c_WIDX_W-1:0]   r_widx, w_widx_inc;
    logic [DATA_W-1:0]     r_wdata, r_word0;

    logic                  r_mem_re, w_mem_re_nxt;
    logic [3:0]            r_mem_wr, w_mem_wr_nxt;
    logic [DM_ADDRESS-1:0] r_mem_addr, w_mem_addr_nxt;
    logic [DATA_W-1:0]     r_mem_wdata, w_mem_wdata_nxt;
    logic                  r_resp_valid;
    logic [DATA_W-1:0]     r_resp_rdata;

    logic                  w_sel_we, w_sel_uns;
    size_t                 w_sel_size;
    logic [1:0]            w_sel_off;
    logic [c_WIDX_W-1:0]   w_sel_widx;
    logic [DATA_W-1:0]     w_sel_wdata, w_word0;
    logic [DATA_W-1:0]     w_rot, w_ext;
    logic [7:0]            w_mask;
    logic                  w_split;

    // In IDLE the first access is computed straight from the request so that
    // the registered strobes appear in the cycle the FSM sits in ACC0.
    always_comb begin
        w_sel_we    = r_we;
        w_sel_uns   = r_uns;
        w_sel_size  = r_size;
        w_sel_off   = r_off;
        w_sel_widx  = r_widx;
        w_sel_wdata = r_wdata;
        if (r_state == IDLE) begin
            w_sel_we    = bus.req_we;
            w_sel_uns   = f3_unsigned(bus.req_funct3);
            w_sel_size  = f3_size(bus.req_funct3);
            w_sel_off   = bus.req_addr[1:0];
            w_sel_widx  = bus.req_addr[DM_ADDRESS-1:2];
            w_sel_wdata = bus.req_wdata;
        end
        w_widx_inc = r_widx + c_WIDX_W'(1);
        w_word0    = r_split ? r_word0 : bus.mem_rdata;
    end

    lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
        .i_size      (w_sel_size),
        .i_uns       (w_sel_uns),
        .i_off       (w_sel_off),
        .i_wdata     (w_sel_wdata),
        .i_word0     (w_word0),
        .i_word1     (bus.mem_rdata),
        .o_wdata_rot (w_rot),
        .o_mask      (w_mask),
        .o_split     (w_split),
        .o_rdata_ext (w_ext)
    );

    always_comb begin
        w_state_nxt     = r_state;
        w_mem_re_nxt    = 1'b0;
        w_mem_wr_nxt    = 4'b0000;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    w_state_nxt     = ACC0;
                    w_mem_re_nxt    = ~w_sel_we;
                    w_mem_wr_nxt    = w_sel_we ? w_mask[3:0] : 4'b0000;
                    w_mem_addr_nxt  = {w_sel_widx, 2'b00};
                    w_mem_wdata_nxt = w_sel_we ? w_rot : '0;
                end
            end
            ACC0: begin
                if (r_split) begin
                    w_state_nxt     = ACC1;
                    w_mem_re_nxt    = ~r_we;
                    w_mem_wr_nxt    = r_we ? w_mask[7:4] : 4'b0000;
                    w_mem_addr_nxt  = {w_widx_inc, 2'b00};
                    w_mem_wdata_nxt = r_we ? w_rot : '0;
                end else begin
                    w_state_nxt = FIN;
                end
            end
            ACC1:    w_state_nxt = FIN;
            FIN:     w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_we         <= 1'b0;
            r_uns        <= 1'b0;
            r_split      <= 1'b0;
            r_size       <= SZ_B;
            r_off        <= 2'b00;
            r_widx       <= '0;
            r_wdata      <= '0;
            r_word0      <= '0;
            r_mem_re     <= 1'b0;
            r_mem_wr     <= 4'b0000;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
        end else begin
            r_mem_re     <= w_mem_re_nxt;
            r_mem_wr     <= w_mem_wr_nxt;
            r_mem_addr   <= w_mem_addr_nxt;
            r_mem_wdata  <= w_mem_wdata_nxt;
            r_resp_valid <= (r_state == FIN);
            if (r_state == IDLE && bus.req_valid) begin
                r_we    <= w_sel_we;
                r_uns   <= w_sel_uns;
                r_size  <= w_sel_size;
                r_off   <= w_sel_off;
                r_widx  <= w_sel_widx;
                r_wdata <= w_sel_wdata;
                r_split <= w_split;
            end
            if (r_state == ACC1) r_word0 <= bus.mem_rdata;
            if (r_state == FIN)  r_resp_rdata <= r_we ? '0 : w_ext;
        end
    end

    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_resp_rdata;
    assign bus.mem_re     = r_mem_re;
    assign bus.mem_wr     = r_mem_wr;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
endmodule
`default_nettype wire

// File: tb/tb_lsu_misalign_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_misalign_unit
// Purpose  : Scoreboard bench for lsu_misalign_unit with a word memory model.
// Revision : 1.0
// ============================================================================
module tb_lsu_misalign_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic mem_init = 1'b1;
    always #5 clk = ~clk;

    lsu_misalign_unit_if #(.DM_ADDRESS(9), .DATA_W(32)) bus ();

    lsu_misalign_unit #(.DM_ADDRESS(9), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] rdata;
        int          lat;
    } resp_t;

    typedef struct {
        logic [8:0]  addr;
        logic        re;
        logic [3:0]  wr;
        logic [31:0] wdata;
    } acc_t;

    resp_t       resp_q[$];
    acc_t        acc_q[$];
    int          accept_q[$];
    int          n_pass = 0;
    int          n_tot  = 0;
    int          cyc    = 0;
    logic [31:0] mem [0:127];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'h0;
            mem[0]   <= 32'h88776655;
            mem[127] <= 32'h44332211;
        end else begin
            for (int i = 0; i < 4; i++)
                if (bus.mem_wr[i]) mem[bus.mem_addr[8:2]][8*i +: 8] <= bus.mem_wdata[8*i +: 8];
            if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[8:2]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [31:0] lanes(input logic [3:0] wr);
        return {{8{wr[3]}}, {8{wr[2]}}, {8{wr[1]}}, {8{wr[0]}}};
    endfunction

    acc_t        m_acc;
    resp_t       m_resp;
    int          m_t;
    logic [31:0] m_lm;

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.req_valid && bus.req_ready) accept_q.push_back(cyc + 1);
            if (bus.mem_re || bus.mem_wr != 4'b0000) begin
                if (acc_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL mem_unexpected: got addr 0x%0h re %0b wr %b, none required",
                             bus.mem_addr, bus.mem_re, bus.mem_wr);
                end else begin
                    m_acc = acc_q.pop_front();
                    m_lm  = lanes(m_acc.wr);
                    check("mem_access",
                          {18'd0, bus.mem_addr, bus.mem_re, bus.mem_wr, bus.mem_wdata & m_lm},
                          {18'd0, m_acc.addr, m_acc.re, m_acc.wr, m_acc.wdata & m_lm});
                end
            end
            if (bus.resp_valid) begin
                if (resp_q.size() == 0 || accept_q.size() == 0) begin
                    n_tot++;
                    $display("FAIL resp_unexpected: got rdata 0x%0h, no response required", bus.resp_rdata);
                end else begin
                    m_resp = resp_q.pop_front();
                    m_t    = accept_q.pop_front();
                    check("resp_rdata", {32'd0, bus.resp_rdata}, {32'd0, m_resp.rdata});
                    check("resp_latency", 64'(cyc - m_t), 64'(m_resp.lat));
                end
            end
        end
    end

    task automatic exp_acc(input logic [8:0] a, input logic re, input logic [3:0] wr, input logic [31:0] wd);
        acc_t e;
        e.addr = a; e.re = re; e.wr = wr; e.wdata = wd;
        acc_q.push_back(e);
    endtask

    task automatic exp_resp(input logic [31:0] rd, input int lat);
        resp_t e;
        e.rdata = rd; e.lat = lat;
        resp_q.push_back(e);
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [8:0] addr,
                         input logic [31:0] wd, output int t_acc);
        int n = 0;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wd;
        bus.req_valid  = 1'b1;
        @(negedge clk);
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            n_tot++;
            $display("FAIL accept_timeout: got req_ready 0 for 50 cycles, required 1");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        t_acc = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_sw, t_lw, t, n;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        mem_init = 1'b0;
        check("rst_req_ready",  64'(bus.req_ready),  64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_rdata", 64'(bus.resp_rdata), 64'd0);
        check("rst_mem_re",     64'(bus.mem_re),     64'd0);
        check("rst_mem_wr",     64'(bus.mem_wr),     64'd0);
        check("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
        check("rst_mem_wdata",  64'(bus.mem_wdata),  64'd0);

        // SW then LW issued back-to-back: the LW must enter on the resp cycle.
        exp_acc(9'h010, 1'b0, 4'b1111, 32'hDEADBEEF); exp_resp(32'h0, 2);
        issue(1'b1, F3_W, 9'h010, 32'hDEADBEEF, t_sw);
        exp_acc(9'h010, 1'b1, 4'b0000, 32'h0); exp_resp(32'hDEADBEEF, 2);
        issue(1'b0, F3_W, 9'h010, 32'h0, t_lw);
        check("b2b_accept_gap", 64'(t_lw - t_sw), 64'd3);

        exp_acc(9'h010, 1'b0, 4'b1000, 32'hA5000000); exp_resp(32'h0, 2);
        issue(1'b1, F3_B, 9'h013, 32'h000000A5, t);
        exp_acc(9'h010, 1'b1, 4'b0000, 32'h0); exp_resp(32'hFFFFFFA5, 2);
        issue(1'b0, F3_B, 9'h013, 32'h0, t);
        exp_acc(9'h010, 1'b1, 4'b0000, 32'h0); exp_resp(32'h000000A5, 2);
        issue(1'b0, F3_BU, 9'h013, 32'h0, t);

        exp_acc(9'h020, 1'b0, 4'b1000, 32'h34000012);
        exp_acc(9'h024, 1'b0, 4'b0001, 32'h34000012); exp_resp(32'h0, 3);
        issue(1'b1, F3_H, 9'h023, 32'h00001234, t);
        exp_acc(9'h020, 1'b1, 4'b0000, 32'h0);
        exp_acc(9'h024, 1'b1, 4'b0000, 32'h0); exp_resp(32'h00001234, 3);
        issue(1'b0, F3_HU, 9'h023, 32'h0, t);

        exp_acc(9'h1FC, 1'b1, 4'b0000, 32'h0);
        exp_acc(9'h000, 1'b1, 4'b0000, 32'h0); exp_resp(32'h66554433, 3);
        issue(1'b0, F3_W, 9'h1FE, 32'h0, t);

        exp_acc(9'h010, 1'b1, 4'b0000, 32'h0); exp_resp(32'hFFFFA5AD, 2);
        issue(1'b0, F3_H, 9'h012, 32'h0, t);

        // Split LW dropped by a reset that lands while the FSM is in ACC1.
        exp_acc(9'h0A0, 1'b1, 4'b0000, 32'h0);
        exp_acc(9'h0A4, 1'b1, 4'b0000, 32'h0);
        issue(1'b0, F3_W, 9'h0A1, 32'h0, t);
        @(posedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        check("drop_req_ready",  64'(bus.req_ready),  64'd1);
        check("drop_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("drop_mem_re",     64'(bus.mem_re),     64'd0);
        check("drop_mem_wr",     64'(bus.mem_wr),     64'd0);
        accept_q.delete();

        exp_acc(9'h010, 1'b1, 4'b0000, 32'h0); exp_resp(32'hFFFFFFBE, 2);
        issue(1'b0, F3_B, 9'h011, 32'h0, t);

        // Split SW wrapping from the top word to word 0, then read back.
        exp_acc(9'h1FC, 1'b0, 4'b1110, 32'h22334411);
        exp_acc(9'h000, 1'b0, 4'b0001, 32'h22334411); exp_resp(32'h0, 3);
        issue(1'b1, F3_W, 9'h1FD, 32'h11223344, t);
        exp_acc(9'h1FC, 1'b1, 4'b0000, 32'h0);
        exp_acc(9'h000, 1'b1, 4'b0000, 32'h0); exp_resp(32'h11223344, 3);
        issue(1'b0, F3_W, 9'h1FD, 32'h0, t);

        n = 0;
        while ((resp_q.size() != 0 || acc_q.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", 64'(resp_q.size() + acc_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
`default_nettype wire
